// File: rtl/huff_frame_ctrl.sv
// Frame sequencer for the 6-symbol Huffman coder: histograms FRAME_LEN legal symbols, pulses the coder,
// waits up to TIMEOUT cycles for its table and holds the result (or err) until tbl_ack.
module huff_frame_ctrl #(
  parameter int FRAME_LEN = 100,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sym_valid,
  input  logic [2:0]  sym,
  output logic        sym_ready,
  output logic        cb_rst,
  output logic [7:0]  CNT1,
  output logic [7:0]  CNT2,
  output logic [7:0]  CNT3,
  output logic [7:0]  CNT4,
  output logic [7:0]  CNT5,
  output logic [7:0]  CNT6,
  output logic        CNT_valid,
  input  logic        code_valid,
  input  logic [7:0]  HC1,
  input  logic [7:0]  HC2,
  input  logic [7:0]  HC3,
  input  logic [7:0]  HC4,
  input  logic [7:0]  HC5,
  input  logic [7:0]  HC6,
  input  logic [7:0]  M1,
  input  logic [7:0]  M2,
  input  logic [7:0]  M3,
  input  logic [7:0]  M4,
  input  logic [7:0]  M5,
  input  logic [7:0]  M6,
  output logic [47:0] tbl_hc,
  output logic [47:0] tbl_m,
  output logic        tbl_valid,
  input  logic        tbl_ack,
  output logic        err,
  output logic        bad_sym
);

  typedef enum logic [2:0] {
    S_CLR,
    S_COLLECT,
    S_LAUNCH,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t     state, state_nxt;
  logic       clr_cnt;
  logic [7:0] frame_cnt;
  logic [7:0] wait_cnt;
  logic [7:0] cnt [6];
  logic       accept;
  logic       sym_legal;
  logic       last_sym;
  logic       timeout;

  assign sym_ready = (state == S_COLLECT);
  assign cb_rst    = (state == S_CLR);
  assign CNT_valid = (state == S_LAUNCH);
  assign tbl_valid = (state == S_DONE);
  assign err       = (state == S_ERR);

  assign accept    = sym_valid && (state == S_COLLECT);
  assign sym_legal = (sym >= 3'd1) && (sym <= 3'd6);
  assign last_sym  = accept && sym_legal && (frame_cnt == 8'(FRAME_LEN - 1));
  assign timeout   = (wait_cnt == 8'(TIMEOUT - 1));

  assign CNT1 = cnt[0];
  assign CNT2 = cnt[1];
  assign CNT3 = cnt[2];
  assign CNT4 = cnt[3];
  assign CNT5 = cnt[4];
  assign CNT6 = cnt[5];

  always_ff @(posedge clk) begin
    if (reset) state <= S_CLR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLR:     if (clr_cnt) state_nxt = S_COLLECT;
      S_COLLECT: if (last_sym) state_nxt = S_LAUNCH;
      S_LAUNCH:  state_nxt = S_WAIT;
      // A coder answer in the timeout cycle still counts as a result.
      S_WAIT: begin
        if (code_valid)   state_nxt = S_DONE;
        else if (timeout) state_nxt = S_ERR;
      end
      S_DONE:    if (tbl_ack) state_nxt = S_CLR;
      S_ERR:     if (tbl_ack) state_nxt = S_CLR;
      default:   state_nxt = S_CLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt   <= 1'b0;
      frame_cnt <= '0;
      wait_cnt  <= '0;
      bad_sym   <= 1'b0;
      tbl_hc    <= '0;
      tbl_m     <= '0;
      for (int i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      case (state)
        S_CLR: begin
          // Toggles 0->1 over the two CLR cycles and returns to 0 on exit.
          clr_cnt   <= ~clr_cnt;
          frame_cnt <= '0;
          bad_sym   <= 1'b0;
          for (int i = 0; i < 6; i++) cnt[i] <= '0;
        end
        S_COLLECT: begin
          if (accept) begin
            if (sym_legal) begin
              frame_cnt <= frame_cnt + 8'd1;
              for (int i = 0; i < 6; i++)
                if (sym == 3'(i + 1)) cnt[i] <= cnt[i] + 8'd1;
            end else begin
              bad_sym <= 1'b1;
            end
          end
        end
        S_LAUNCH: wait_cnt <= '0;
        S_WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (code_valid) begin
            tbl_hc <= {HC6, HC5, HC4, HC3, HC2, HC1};
            tbl_m  <= {M6, M5, M4, M3, M2, M1};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_huff_frame_ctrl.sv
// Self-checking bench for huff_frame_ctrl: frame-level histogram model, directed corner sequences,
// a vector table of frame/response scenarios and randomized frames.
`timescale 1ns/1ps
module tb_huff_frame_ctrl;
  localparam int FRAME_LEN = 100;
  localparam int TIMEOUT   = 255;
  localparam int NO_RESP   = -1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sym_valid = 1'b0;
  logic [2:0]  sym = '0;
  logic        code_valid = 1'b0;
  logic        tbl_ack = 1'b0;
  logic [47:0] hc_bus = '0;
  logic [47:0] m_bus = '0;
  logic        sym_ready, cb_rst, CNT_valid, tbl_valid, err, bad_sym;
  logic [7:0]  CNT1, CNT2, CNT3, CNT4, CNT5, CNT6;
  logic [47:0] tbl_hc, tbl_m;

  always #5 clk = ~clk;

  huff_frame_ctrl dut (
    .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym(sym), .sym_ready(sym_ready),
    .cb_rst(cb_rst), .CNT1(CNT1), .CNT2(CNT2), .CNT3(CNT3), .CNT4(CNT4), .CNT5(CNT5), .CNT6(CNT6),
    .CNT_valid(CNT_valid), .code_valid(code_valid),
    .HC1(hc_bus[7:0]), .HC2(hc_bus[15:8]), .HC3(hc_bus[23:16]),
    .HC4(hc_bus[31:24]), .HC5(hc_bus[39:32]), .HC6(hc_bus[47:40]),
    .M1(m_bus[7:0]), .M2(m_bus[15:8]), .M3(m_bus[23:16]),
    .M4(m_bus[31:24]), .M5(m_bus[39:32]), .M6(m_bus[47:40]),
    .tbl_hc(tbl_hc), .tbl_m(tbl_m), .tbl_valid(tbl_valid), .tbl_ack(tbl_ack),
    .err(err), .bad_sym(bad_sym)
  );

  typedef struct {
    int         gap;      // 0 continuous, 1 every other cycle, 2 random
    int         n_bad;
    int         bad_val;  // -1: mix of 0 and 7
    int         delay;    // cycles after LAUNCH before code_valid, NO_RESP for none
    logic [7:0] hc1;
    logic [7:0] m1;
    bit         exp_err;
  } vec_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          exp_cnt[6];
  logic [47:0] last_hc = '0;
  logic [47:0] last_m = '0;
  logic [2:0]  stim[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] cnt_bus();
    return {CNT6, CNT5, CNT4, CNT3, CNT2, CNT1};
  endfunction

  function automatic logic [47:0] exp_bus();
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[i*8 +: 8] = 8'(exp_cnt[i]);
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1; sym_valid = 1'b0; code_valid = 1'b0; tbl_ack = 1'b0;
    step();
    step();
    chk("rst_ctrl", 64'({sym_ready, CNT_valid, tbl_valid, err, bad_sym, cb_rst}), 64'(6'b000001));
    chk("rst_cnt", 64'(cnt_bus()), 64'd0);
    chk("rst_tbl_hc", 64'(tbl_hc), 64'd0);
    chk("rst_tbl_m", 64'(tbl_m), 64'd0);
    reset = 1'b0;
    last_hc = '0;
    last_m = '0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!sym_ready && n < 20) begin
      step();
      n++;
    end
    chk(name, 64'(sym_ready), 64'd1);
  endtask

  task automatic build_random(input int n_bad, input int bad_val);
    logic [2:0] b;
    stim.delete();
    for (int i = 0; i < FRAME_LEN; i++) stim.push_back(3'($urandom_range(1, 6)));
    for (int i = 0; i < n_bad; i++) begin
      if (bad_val < 0) b = ($urandom_range(0, 1) == 1) ? 3'd7 : 3'd0;
      else             b = 3'(bad_val);
      stim.insert(int'($urandom_range(0, stim.size() - 1)), b);
    end
  endtask

  // Reference: histogram of the first FRAME_LEN legal symbols offered; launch right after the last one.
  task automatic run_frame(input int gap);
    int         legal = 0;
    int         cyc = 0;
    bit         bad = 1'b0;
    bit         early = 1'b0;
    bit         v;
    logic [2:0] s;
    for (int i = 0; i < 6; i++) exp_cnt[i] = 0;
    while (legal < FRAME_LEN && cyc < 4000 && stim.size() > 0) begin
      v = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 1) == 1);
      s = v ? stim.pop_front() : 3'($urandom_range(0, 7));
      sym_valid = v;
      sym = s;
      step();
      if (v) begin
        if (s >= 3'd1 && s <= 3'd6) begin
          exp_cnt[s - 1]++;
          legal++;
        end else begin
          bad = 1'b1;
        end
      end
      if (legal < FRAME_LEN && CNT_valid) early = 1'b1;
      cyc++;
    end
    sym_valid = 1'b0;
    sym = '0;
    chk("no_early_launch", 64'(early), 64'd0);
    chk("launch_pulse", 64'(CNT_valid), 64'd1);
    chk("ready_drop", 64'(sym_ready), 64'd0);
    chk("counts", 64'(cnt_bus()), 64'(exp_bus()));
    chk("bad_sym", 64'(bad_sym), 64'(bad));
  endtask

  // Called in the LAUNCH cycle. WAIT starts one cycle later; timeout lands TIMEOUT cycles into WAIT.
  task automatic do_response(input int d, input logic [47:0] hc, input logic [47:0] m, input bit exp_err);
    int err_at = -1;
    int limit;
    bit tv_early = 1'b0;
    bit cv_long = 1'b0;
    limit = (d == NO_RESP) ? TIMEOUT + 40 : d;
    for (int k = 1; k <= limit; k++) begin
      hc_bus = 48'({$urandom(), $urandom()});
      m_bus  = 48'({$urandom(), $urandom()});
      step();
      if (CNT_valid) cv_long = 1'b1;
      if (tbl_valid) tv_early = 1'b1;
      if (err && err_at < 0) err_at = k;
    end
    if (d != NO_RESP) begin
      code_valid = 1'b1;
      hc_bus = hc;
      m_bus = m;
      step();
      code_valid = 1'b0;
      if (err && err_at < 0) err_at = d + 1;
    end
    chk("cnt_valid_width", 64'(cv_long), 64'd0);
    chk("no_early_tbl_valid", 64'(tv_early), 64'd0);
    chk("err_timing", 64'(err_at), exp_err ? 64'(1 + TIMEOUT) : 64'(-1));
    chk("err_flag", 64'(err), 64'(exp_err));
    chk("tbl_valid", 64'(tbl_valid), 64'(!exp_err));
    if (!exp_err) begin
      last_hc = hc;
      last_m = m;
    end
    chk("tbl_hc", 64'(tbl_hc), 64'(last_hc));
    chk("tbl_m", 64'(tbl_m), 64'(last_m));
    chk("cnt_hold", 64'(cnt_bus()), 64'(exp_bus()));
  endtask

  task automatic ack_and_clear(input bit exp_err);
    int n = 0;
    step();
    chk("hold_status", 64'({tbl_valid, err}), exp_err ? 64'(2'b01) : 64'(2'b10));
    tbl_ack = 1'b1;
    step();
    tbl_ack = 1'b0;
    chk("ack_clears", 64'({tbl_valid, err}), 64'd0);
    while (cb_rst && n < 10) begin
      n++;
      step();
    end
    chk("cb_rst_len", 64'(n), 64'd2);
    chk("collect_after_clr", 64'(sym_ready), 64'd1);
    chk("cnt_cleared", 64'(cnt_bus()), 64'd0);
    chk("bad_cleared", 64'(bad_sym), 64'd0);
    chk("tbl_hc_kept", 64'(tbl_hc), 64'(last_hc));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [47:0] hc, m;
    int          d;
    bit          e;
    bit          spurious;

    vecs[0] = '{gap:1, n_bad:3, bad_val:7,  delay:5,       hc1:8'h01, m1:8'h01, exp_err:1'b0};
    vecs[1] = '{gap:2, n_bad:2, bad_val:-1, delay:TIMEOUT, hc1:8'h5A, m1:8'h0F, exp_err:1'b0};
    vecs[2] = '{gap:0, n_bad:1, bad_val:0,  delay:TIMEOUT+1, hc1:8'hC3, m1:8'h3F, exp_err:1'b1};
    vecs[3] = '{gap:2, n_bad:0, bad_val:-1, delay:NO_RESP, hc1:8'h77, m1:8'h07, exp_err:1'b1};
    vecs[4] = '{gap:1, n_bad:0, bad_val:-1, delay:1,       hc1:8'h02, m1:8'h03, exp_err:1'b0};
    vecs[5] = '{gap:0, n_bad:4, bad_val:-1, delay:TIMEOUT-1, hc1:8'hFE, m1:8'hFF, exp_err:1'b0};

    do_reset();
    wait_ready("ready_after_reset");

    // code_valid and tbl_ack while collecting must be ignored.
    code_valid = 1'b1; tbl_ack = 1'b1; hc_bus = 48'hABCDEF012345; m_bus = 48'h111111111111;
    step();
    code_valid = 1'b0; tbl_ack = 1'b0;
    chk("cv_in_collect_tbl", 64'(tbl_hc), 64'd0);
    chk("cv_in_collect_state", 64'({sym_ready, tbl_valid}), 64'(2'b10));

    // Directed full frame 30/20/15/15/12/8.
    stim.delete();
    for (int i = 0; i < 30; i++) stim.push_back(3'd1);
    for (int i = 0; i < 20; i++) stim.push_back(3'd2);
    for (int i = 0; i < 15; i++) stim.push_back(3'd3);
    for (int i = 0; i < 15; i++) stim.push_back(3'd4);
    for (int i = 0; i < 12; i++) stim.push_back(3'd5);
    for (int i = 0; i < 8; i++)  stim.push_back(3'd6);
    run_frame(0);
    chk("directed_counts", 64'(cnt_bus()), 64'({8'd8, 8'd12, 8'd15, 8'd15, 8'd20, 8'd30}));
    do_response(5, {40'h123456789A, 8'h01}, {40'hFFEEDDCCBB, 8'h01}, 1'b0);
    chk("hc1_byte", 64'(tbl_hc[7:0]), 64'h01);
    chk("m1_byte", 64'(tbl_m[7:0]), 64'h01);
    ack_and_clear(1'b0);

    // Reset after 40 symbols: partial histogram discarded, no launch.
    spurious = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sym_valid = 1'b1;
      sym = 3'($urandom_range(1, 6));
      step();
      if (CNT_valid) spurious = 1'b1;
    end
    do_reset();
    chk("no_spurious_launch", 64'(spurious), 64'd0);
    wait_ready("ready_after_mid_reset");
    build_random(0, -1);
    run_frame(0);
    do_response(10, 48'h0A0B0C0D0E0F, 48'h010203040506, 1'b0);

    // Reset while holding a result in DONE, then while in WAIT.
    do_reset();
    wait_ready("ready_after_done_reset");
    build_random(1, 7);
    run_frame(0);
    step(); step(); step();
    do_reset();
    wait_ready("ready_after_wait_reset");

    for (int i = 0; i < 6; i++) begin
      build_random(vecs[i].n_bad, vecs[i].bad_val);
      run_frame(vecs[i].gap);
      hc = {32'($urandom()), 8'($urandom()), vecs[i].hc1};
      m  = {32'($urandom()), 8'($urandom()), vecs[i].m1};
      do_response(vecs[i].delay, hc, m, vecs[i].exp_err);
      ack_and_clear(vecs[i].exp_err);
    end

    for (int i = 0; i < 8; i++) begin
      build_random(int'($urandom_range(0, 4)), -1);
      run_frame(int'($urandom_range(0, 2)));
      if ($urandom_range(0, 4) == 0) d = NO_RESP;
      else                           d = int'($urandom_range(1, TIMEOUT + 5));
      e = (d == NO_RESP) || (d > TIMEOUT);
      hc = 48'({$urandom(), $urandom()});
      m  = 48'({$urandom(), $urandom()});
      do_response(d, hc, m, e);
      ack_and_clear(e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
